// File: rtl/hall_commutator_if.sv
// Hall commutator channel bus: raw hall/control inputs toward the block and
// decoded phase selects, filtered hall, position and status flags back out.
interface hall_commutator_if #(
  parameter int CNT_WIDTH = 16
);
  logic [2:0]           hall;
  logic                 enable;
  logic                 dir;
  logic                 fault_clr;
  logic [2:0]           u;
  logic [2:0]           z;
  logic [2:0]           hall_filt;
  logic [CNT_WIDTH-1:0] position;
  logic                 seq_err;
  logic                 fault;

  modport master (
    output hall, enable, dir, fault_clr,
    input  u, z, hall_filt, position, seq_err, fault
  );

  modport slave (
    input  hall, enable, dir, fault_clr,
    output u, z, hall_filt, position, seq_err, fault
  );
endinterface

// File: rtl/hall_commutator.sv
// BLDC commutation for one motor channel: hall sync + glitch filter, table
// decode to registered phase selects, sequence checking, position and fault.
module hall_commutator #(
  parameter int FILTER_CYCLES = 4,
  parameter int FAULT_CYCLES  = 1000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hall_commutator_if.slave bus
);
  localparam logic [7:0]  STAB_MAX  = 8'(FILTER_CYCLES - 1);
  localparam logic [15:0] FAULT_MAX = 16'(FAULT_CYCLES);

  logic [2:0]           s1_q, s2_q;
  logic [2:0]           cand_q, cand_d;
  logic [7:0]           stab_cnt_q, stab_cnt_d;
  logic [2:0]           hall_filt_q, hall_filt_d;
  logic                 first_valid_q, first_valid_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic                 seq_err_q, seq_err_d;
  logic [15:0]          inv_cnt_q, inv_cnt_d;
  logic                 fault_q, fault_d;
  logic [2:0]           u_q, u_d, z_q, z_d;
  logic [2:0]           fu, fz;
  logic [2:0]           i_old, i_new;

  function automatic logic valid_h(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  function automatic logic [2:0] seq_idx(input logic [2:0] h);
    case (h)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [2:0] seq_nxt(input logic [2:0] i);
    return (i == 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

  always_comb begin
    // Filter: accept on the clock the counter reaches STAB_MAX, so a value
    // seen FILTER_CYCLES consecutive times in s2 is taken (also FILTER_CYCLES=1).
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    if (s2_q != cand_q) begin
      cand_d     = s2_q;
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end
    hall_filt_d = (stab_cnt_d == STAB_MAX) ? s2_q : hall_filt_q;

    pos_d         = pos_q;
    seq_err_d     = 1'b0;
    first_valid_d = valid_h(hall_filt_d);
    i_old         = seq_idx(hall_filt_q);
    i_new         = seq_idx(hall_filt_d);
    if (valid_h(hall_filt_d) && first_valid_q && (hall_filt_d != hall_filt_q)) begin
      if (i_new == seq_nxt(i_old))      pos_d = pos_q + 1'b1;
      else if (i_old == seq_nxt(i_new)) pos_d = pos_q - 1'b1;
      else                              seq_err_d = 1'b1;
    end

    inv_cnt_d = 16'd0;
    if (!valid_h(hall_filt_q))
      inv_cnt_d = (inv_cnt_q == FAULT_MAX) ? inv_cnt_q : inv_cnt_q + 16'd1;
    fault_d = fault_q;
    if (bus.fault_clr && valid_h(hall_filt_q)) fault_d = 1'b0;
    if (inv_cnt_d == FAULT_MAX)                fault_d = 1'b1;

    case (hall_filt_q)
      3'b101:  begin fu = 3'b100; fz = 3'b001; end
      3'b100:  begin fu = 3'b100; fz = 3'b010; end
      3'b110:  begin fu = 3'b010; fz = 3'b100; end
      3'b010:  begin fu = 3'b010; fz = 3'b001; end
      3'b011:  begin fu = 3'b001; fz = 3'b010; end
      3'b001:  begin fu = 3'b001; fz = 3'b100; end
      default: begin fu = 3'b000; fz = 3'b111; end
    endcase
    // Reverse drive swaps high and low phases; the floating phase is unchanged.
    u_d = bus.dir ? ~(fu | fz) : fu;
    z_d = fz;
    if (!valid_h(hall_filt_q) || !bus.enable || fault_q) begin
      u_d = 3'b000;
      z_d = 3'b111;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= 3'b000;
      s2_q          <= 3'b000;
      cand_q        <= 3'b000;
      stab_cnt_q    <= 8'd0;
      hall_filt_q   <= 3'b000;
      first_valid_q <= 1'b0;
      pos_q         <= '0;
      seq_err_q     <= 1'b0;
      inv_cnt_q     <= 16'd0;
      fault_q       <= 1'b0;
      u_q           <= 3'b000;
      z_q           <= 3'b111;
    end else begin
      s1_q          <= bus.hall;
      s2_q          <= s1_q;
      cand_q        <= cand_d;
      stab_cnt_q    <= stab_cnt_d;
      hall_filt_q   <= hall_filt_d;
      first_valid_q <= first_valid_d;
      pos_q         <= pos_d;
      seq_err_q     <= seq_err_d;
      inv_cnt_q     <= inv_cnt_d;
      fault_q       <= fault_d;
      u_q           <= u_d;
      z_q           <= z_d;
    end
  end

  assign bus.u         = u_q;
  assign bus.z         = z_q;
  assign bus.hall_filt = hall_filt_q;
  assign bus.position  = pos_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_hall_commutator.sv
// Directed bench for hall_commutator: vector table for steady-state decode and
// position, hand sequences for latency, glitch, fault, async reset and wrap.
module tb_hall_commutator;
  localparam int FILT = 4;
  localparam int FLT  = 20;
  localparam int CW   = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  hall_commutator_if #(.CNT_WIDTH(CW)) bus ();

  hall_commutator #(.FILTER_CYCLES(FILT), .FAULT_CYCLES(FLT), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] hall;
    logic       dir;
    logic       en;
    logic [2:0] eu;
    logic [2:0] ez;
    logic [3:0] epos;
    int         eseq;
  } vec_t;

  vec_t vt [29];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int sc;
      bus.hall   = vt[i].hall;
      bus.dir    = vt[i].dir;
      bus.enable = vt[i].en;
      sc = 0;
      repeat (10) begin
        tick();
        sc += int'(bus.seq_err);
      end
      chk($sformatf("v%0d_u", i),    32'(bus.u),         32'(vt[i].eu));
      chk($sformatf("v%0d_z", i),    32'(bus.z),         32'(vt[i].ez));
      chk($sformatf("v%0d_hf", i),   32'(bus.hall_filt), 32'(vt[i].hall));
      chk($sformatf("v%0d_pos", i),  32'(bus.position),  32'(vt[i].epos));
      chk($sformatf("v%0d_seq", i),  32'(sc),            32'(vt[i].eseq));
    end
  endtask

  initial begin
    int sc;
    n_cmp = 0;
    n_bad = 0;

    // forward rotation, dir=0
    vt[0]  = '{3'b100, 1'b0, 1'b1, 3'b100, 3'b010, 4'h1, 0};
    vt[1]  = '{3'b110, 1'b0, 1'b1, 3'b010, 3'b100, 4'h2, 0};
    vt[2]  = '{3'b010, 1'b0, 1'b1, 3'b010, 3'b001, 4'h3, 0};
    vt[3]  = '{3'b011, 1'b0, 1'b1, 3'b001, 3'b010, 4'h4, 0};
    vt[4]  = '{3'b001, 1'b0, 1'b1, 3'b001, 3'b100, 4'h5, 0};
    vt[5]  = '{3'b101, 1'b0, 1'b1, 3'b100, 3'b001, 4'h6, 0};
    // reverse rotation, dir=0
    vt[6]  = '{3'b001, 1'b0, 1'b1, 3'b001, 3'b100, 4'h5, 0};
    vt[7]  = '{3'b011, 1'b0, 1'b1, 3'b001, 3'b010, 4'h4, 0};
    vt[8]  = '{3'b010, 1'b0, 1'b1, 3'b010, 3'b001, 4'h3, 0};
    vt[9]  = '{3'b110, 1'b0, 1'b1, 3'b010, 3'b100, 4'h2, 0};
    vt[10] = '{3'b100, 1'b0, 1'b1, 3'b100, 3'b010, 4'h1, 0};
    vt[11] = '{3'b101, 1'b0, 1'b1, 3'b100, 3'b001, 4'h0, 0};
    // reverse rotation, dir=1 (reverse table), position -1..-6
    vt[12] = '{3'b001, 1'b1, 1'b1, 3'b010, 3'b100, 4'hF, 0};
    vt[13] = '{3'b011, 1'b1, 1'b1, 3'b100, 3'b010, 4'hE, 0};
    vt[14] = '{3'b010, 1'b1, 1'b1, 3'b100, 3'b001, 4'hD, 0};
    vt[15] = '{3'b110, 1'b1, 1'b1, 3'b001, 3'b100, 4'hC, 0};
    vt[16] = '{3'b100, 1'b1, 1'b1, 3'b001, 3'b010, 4'hB, 0};
    vt[17] = '{3'b101, 1'b1, 1'b1, 3'b010, 3'b001, 4'hA, 0};
    vt[18] = '{3'b100, 1'b0, 1'b1, 3'b100, 3'b010, 4'hB, 0};
    // back to 101, then illegal jump 101 -> 010
    vt[19] = '{3'b101, 1'b0, 1'b1, 3'b100, 3'b001, 4'hA, 0};
    vt[20] = '{3'b010, 1'b0, 1'b1, 3'b010, 3'b001, 4'hA, 1};
    // wrap run after reset, enable dropped for two steps
    vt[21] = '{3'b100, 1'b0, 1'b1, 3'b100, 3'b010, 4'h1, 0};
    vt[22] = '{3'b110, 1'b0, 1'b1, 3'b010, 3'b100, 4'h2, 0};
    vt[23] = '{3'b010, 1'b0, 1'b1, 3'b010, 3'b001, 4'h3, 0};
    vt[24] = '{3'b011, 1'b0, 1'b0, 3'b000, 3'b111, 4'h4, 0};
    vt[25] = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b111, 4'h5, 0};
    vt[26] = '{3'b101, 1'b0, 1'b1, 3'b100, 3'b001, 4'h6, 0};
    vt[27] = '{3'b100, 1'b0, 1'b1, 3'b100, 3'b010, 4'h7, 0};
    vt[28] = '{3'b110, 1'b0, 1'b1, 3'b010, 3'b100, 4'h8, 0};

    rst_n         = 1'b0;
    bus.hall      = 3'b101;
    bus.enable    = 1'b1;
    bus.dir       = 1'b0;
    bus.fault_clr = 1'b0;
    tick();
    tick();
    chk("rst_u",    32'(bus.u),         32'h0);
    chk("rst_z",    32'(bus.z),         32'h7);
    chk("rst_hf",   32'(bus.hall_filt), 32'h0);
    chk("rst_pos",  32'(bus.position),  32'h0);
    chk("rst_seq",  32'(bus.seq_err),   32'h0);
    chk("rst_flt",  32'(bus.fault),     32'h0);

    // first-state latency: outputs off until edge FILT+3
    rst_n = 1'b1;
    sc = 0;
    for (int k = 1; k <= FILT + 3; k++) begin
      tick();
      sc += int'(bus.seq_err);
      if (k < FILT + 3) begin
        chk($sformatf("lat%0d_u", k), 32'(bus.u), 32'h0);
        chk($sformatf("lat%0d_z", k), 32'(bus.z), 32'h7);
      end else begin
        chk("lat_u", 32'(bus.u), 32'h4);
        chk("lat_z", 32'(bus.z), 32'h1);
      end
    end
    chk("lat_pos", 32'(bus.position), 32'h0);
    chk("lat_seq", 32'(sc),           32'h0);

    run_vecs(0, 18);

    // 3-clock glitch 100 -> 110 must be rejected
    bus.hall = 3'b110;
    repeat (FILT - 1) tick();
    bus.hall = 3'b100;
    sc = 0;
    repeat (10) begin
      tick();
      sc += int'(bus.seq_err);
    end
    chk("gl_hf",  32'(bus.hall_filt), 32'h4);
    chk("gl_u",   32'(bus.u),         32'h4);
    chk("gl_z",   32'(bus.z),         32'h2);
    chk("gl_pos", 32'(bus.position),  32'hB);
    chk("gl_seq", 32'(sc),            32'h0);

    run_vecs(19, 20);

    // invalid hall: outputs off right away, fault after FLT clocks of 111
    bus.hall = 3'b111;
    repeat (FILT + 4) tick();
    chk("inv_u",   32'(bus.u),        32'h0);
    chk("inv_z",   32'(bus.z),        32'h7);
    chk("inv_pos", 32'(bus.position), 32'hA);
    repeat (FLT + FILT + 1 - (FILT + 4)) tick();
    chk("flt_pre", 32'(bus.fault), 32'h0);
    tick();
    chk("flt_set", 32'(bus.fault), 32'h1);
    repeat (4) tick();
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    tick();
    chk("flt_clr_inv", 32'(bus.fault), 32'h1);
    bus.hall = 3'b101;
    sc = 0;
    repeat (10) begin
      tick();
      sc += int'(bus.seq_err);
    end
    chk("flt_hold_u",  32'(bus.u),        32'h0);
    chk("flt_hold_z",  32'(bus.z),        32'h7);
    chk("flt_hold_f",  32'(bus.fault),    32'h1);
    chk("flt_pos",     32'(bus.position), 32'hA);
    chk("flt_seq",     32'(sc),           32'h0);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("flt_clr", 32'(bus.fault), 32'h0);
    tick();
    chk("flt_clr_u", 32'(bus.u), 32'h4);
    chk("flt_clr_z", 32'(bus.z), 32'h1);

    // async reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_u",   32'(bus.u),         32'h0);
    chk("arst_z",   32'(bus.z),         32'h7);
    chk("arst_hf",  32'(bus.hall_filt), 32'h0);
    chk("arst_pos", 32'(bus.position),  32'h0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("arst_rel_u",   32'(bus.u),        32'h4);
    chk("arst_rel_z",   32'(bus.z),        32'h1);
    chk("arst_rel_pos", 32'(bus.position), 32'h0);

    run_vecs(21, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hall_commutator.md
Name: hall_commutator

Overview:
- Clocked, parametrised BLDC commutation block for one motor channel.
- Synchronises and glitch-filters the 3-bit hall input, then decodes it to registered high-phase and high-Z phase selects. Supports both drive directions.
- Adds debounced fault detection, hall sequence-error flagging and a signed hall-step position counter.
- Sits between the hall input pins and the per-phase gate-drive/PWM logic of each motor channel.

Parameters:
- FILTER_CYCLES, 4: consecutive clocks the synchronised hall value must be stable before it is accepted (legal range 1..255).
- FAULT_CYCLES, 1000: consecutive clocks an accepted invalid hall state (000/111) must persist before fault is latched (legal range 1..65535).
- CNT_WIDTH, 16: width of the signed hall-step position counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- hall  input  3  raw hall sensors; bit 2 = hall 1, bit 1 = hall 2, bit 0 = hall 3; asynchronous to clk
- enable  input  1  1 = drive phases per table; 0 = all phases high-Z
- dir  input  1  0 = forward table, 1 = reverse table
- fault_clr  input  1  single-cycle request to clear latched fault
- u  output  3  high-phase select; bit 2 = phase A, bit 1 = B, bit 0 = C
- z  output  3  high-Z select, same bit order; a phase with u=0 and z=0 is driven low
- hall_filt  output  3  current accepted (filtered) hall state
- position  output  CNT_WIDTH  signed hall-step count
- seq_err  output  1  one-cycle pulse on an illegal hall transition
- fault  output  1  sticky fault flag

Behaviour:
- Reset (async assert, sync release): u=000, z=111, hall_filt=000, position=0, seq_err=0, fault=0, filter counters=0, first_valid flag=0.
- Synchroniser: two flip-flop stages on hall, giving s2.
- Filter:
  - cand holds the last s2 value; stab_cnt counts consecutive clocks with s2==cand.
  - If s2!=cand: cand<=s2, stab_cnt<=0.
  - When stab_cnt reaches FILTER_CYCLES-1 and s2==cand: hall_filt<=cand. stab_cnt saturates.
  - Pulses shorter than FILTER_CYCLES clocks never reach hall_filt.
- Latency: a clean hall edge reaches u/z in FILTER_CYCLES+3 clk edges (2 sync + FILTER_CYCLES filter + 1 output register).
- Forward table, hall_filt -> u/z:
  - 101 -> u=100, z=001
  - 100 -> u=100, z=010
  - 110 -> u=010, z=100
  - 010 -> u=010, z=001
  - 011 -> u=001, z=010
  - 001 -> u=001, z=100
- Reverse table (dir=1): z is unchanged; u becomes the phase that is low in the forward table. Example: 101 -> u=010, z=001.
- Forced all-off (u=000, z=111) when hall_filt is 000 or 111, when enable=0, or when fault=1. A dir change takes effect on the next output register update.
- Sequence index: 101=0, 100=1, 110=2, 010=3, 011=4, 001=5. Index 0->5 is CCW.
- On each change of hall_filt between two valid states:
  - index +1 mod 6: position +1.
  - index -1 mod 6: position -1.
  - any other step: seq_err=1 for one clock, position unchanged.
- Position wraps modulo 2^CNT_WIDTH (two's complement). Counting continues regardless of enable and fault.
- The first valid state after reset, or after any invalid state, sets first_valid and never counts or flags seq_err.
- Fault:
  - Invalid counter increments each clock hall_filt is 000/111 and clears on any valid state.
  - On reaching FAULT_CYCLES, fault<=1 (sticky).
  - fault_clr clears fault only if hall_filt is valid in that cycle; otherwise it is ignored.
  - If fault_clr and the fault-set condition coincide, set wins.
- Async reset mid-operation returns everything to reset values immediately. After release, u/z stay all-off until a valid state passes the filter.

Test Plan:
- Reset, hall=101, enable=1, dir=0 -> u=000/z=111 until edge FILTER_CYCLES+3, then u=100, z=001; position=0, seq_err never asserted.
- Forward rotation 101,100,110,010,011,001,101, each held 10 clocks -> u/z follow the forward table; position=+6; seq_err=0. Repeat with reverse order -> position=-6, and with dir=1 -> u per reverse table.
- Glitch: hall 100 -> 110 for 3 clocks (FILTER_CYCLES=4) -> hall_filt stays 100, u/z unchanged, position unchanged.
- Step 101 -> 010 -> seq_err high for exactly 1 clock, position unchanged, u=010, z=001.
- hall=111 held FAULT_CYCLES+5 clocks -> u/z all-off at once, fault=1 after FAULT_CYCLES. fault_clr while hall=111 -> fault stays 1. Restore 101, then pulse fault_clr -> fault=0, u=100, z=001.
- Wrap: CNT_WIDTH=4, 8 forward steps -> position sequence 1..7, then -8. enable=0 mid-run -> u=000, z=111 next update while position keeps counting.
